// File: rtl/regfile_sb_if.sv
// Register-file port bundle: write port, two read ports, allocation and debug read.
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              alloc;
  logic [ADDR_W-1:0] alloc_addr;
  logic              busy1;
  logic              busy2;
  logic              busy_any;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, alloc, alloc_addr, dbg_sel,
    input  rdata1, rdata2, busy1, busy2, busy_any, dbg_data
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, alloc, alloc_addr, dbg_sel,
    output rdata1, rdata2, busy1, busy2, busy_any, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one synchronous
// write port, optional hard-wired zero register, write-to-read bypass and a
// per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 0,
  parameter int BYPASS  = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic hit1;
  logic hit2;
  logic alloc_hit1;
  logic alloc_hit2;

  // Reset image: register i holds i+1, except a hard-wired zero register.
  function automatic logic [DATA_W-1:0] reset_val(input int idx);
    if ((R0_ZERO != 0) && (idx == 0)) begin
      return '0;
    end
    return DATA_W'(idx + 1);
  endfunction

  // Next register contents: single write port, register 0 frozen when hard-wired.
  always_comb begin
    regs_d = regs_q;
    if (bus.we && !((R0_ZERO != 0) && (bus.waddr == '0))) begin
      regs_d[bus.waddr] = bus.wdata;
    end
  end

  // Next busy bits: a new allocation outranks a completing write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.alloc && (bus.alloc_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (bus.we && (bus.waddr == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (R0_ZERO != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // State registers; reset drops pending allocations and in-flight writes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= reset_val(i);
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign hit1       = (BYPASS != 0) && bus.we && (bus.waddr == bus.raddr1);
  assign hit2       = (BYPASS != 0) && bus.we && (bus.waddr == bus.raddr2);
  assign alloc_hit1 = bus.alloc && (bus.alloc_addr == bus.raddr1);
  assign alloc_hit2 = bus.alloc && (bus.alloc_addr == bus.raddr2);

  // Read ports: forwarded write data wins over the array, the zero register wins over both.
  always_comb begin
    bus.rdata1 = hit1 ? bus.wdata : regs_q[bus.raddr1];
    bus.rdata2 = hit2 ? bus.wdata : regs_q[bus.raddr2];
    if ((R0_ZERO != 0) && (bus.raddr1 == '0)) begin
      bus.rdata1 = '0;
    end
    if ((R0_ZERO != 0) && (bus.raddr2 == '0)) begin
      bus.rdata2 = '0;
    end
  end

  // Busy outputs: a forwarded write clears the hazard unless a new producer claims it this cycle.
  always_comb begin
    bus.busy1 = busy_q[bus.raddr1];
    bus.busy2 = busy_q[bus.raddr2];
    if (hit1 && !alloc_hit1) begin
      bus.busy1 = 1'b0;
    end
    if (hit2 && !alloc_hit2) begin
      bus.busy2 = 1'b0;
    end
  end

  // Drain indicator and raw debug view come from registered state only.
  always_comb begin
    bus.busy_any = |busy_q;
    bus.dbg_data = regs_q[bus.dbg_sel];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: four register-file configurations driven with the same
// stimulus; a reference model predicts each cycle's outputs into a queue and
// a monitor pops and compares on the falling edge.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(8),  .ADDR_W(3)) if0 ();
  regfile_sb_if #(.DATA_W(8),  .ADDR_W(3)) if1 ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) if2 ();
  regfile_sb_if #(.DATA_W(8),  .ADDR_W(3)) if3 ();

  regfile_sb #(.DATA_W(8),  .ADDR_W(3), .R0_ZERO(0), .BYPASS(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  regfile_sb #(.DATA_W(8),  .ADDR_W(3), .R0_ZERO(1), .BYPASS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .R0_ZERO(0), .BYPASS(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  regfile_sb #(.DATA_W(8),  .ADDR_W(3), .R0_ZERO(0), .BYPASS(0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    bit          we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    bit          alloc;
    logic [3:0]  aaddr;
    logic [3:0]  dsel;
  } stim_t;

  typedef struct packed {
    logic [3:0][15:0] rd1;
    logic [3:0][15:0] rd2;
    logic [3:0][15:0] dbg;
    logic [3:0]       b1;
    logic [3:0]       b2;
    logic [3:0]       bany;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: plain arrays of register values and busy flags per configuration.
  logic [15:0] mem [4][16];
  bit          bsy [4][16];

  function automatic int dw(input int k);  return (k == 2) ? 16 : 8; endfunction
  function automatic bit r0(input int k);  return (k == 1); endfunction
  function automatic bit bp(input int k);  return (k != 3); endfunction
  function automatic logic [15:0] dmask(input int k); return (dw(k) == 16) ? 16'hFFFF : 16'h00FF; endfunction
  function automatic logic [3:0]  amask(input int k); return (k == 2) ? 4'hF : 4'h7; endfunction

  function automatic stim_t fit(input stim_t s, input int k);
    stim_t m = s;
    m.waddr = s.waddr & amask(k);
    m.wdata = s.wdata & dmask(k);
    m.ra1   = s.ra1 & amask(k);
    m.ra2   = s.ra2 & amask(k);
    m.aaddr = s.aaddr & amask(k);
    m.dsel  = s.dsel & amask(k);
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        mem[k][i] = 16'(i + 1) & dmask(k);
        bsy[k][i] = 1'b0;
      end
      if (r0(k)) mem[k][0] = 16'h0000;
    end
  endtask

  // Clock-edge effect: the write lands and clears busy, then an allocation (the newer producer) sets it.
  task automatic model_commit(input stim_t s);
    for (int k = 0; k < 4; k++) begin
      stim_t m = fit(s, k);
      if (m.we) begin
        if (!(r0(k) && m.waddr == 0)) mem[k][m.waddr] = m.wdata;
        bsy[k][m.waddr] = 1'b0;
      end
      if (m.alloc && !(r0(k) && m.aaddr == 0)) bsy[k][m.aaddr] = 1'b1;
    end
  endtask

  function automatic logic [15:0] pred_rd(input int k, input stim_t m, input logic [3:0] a);
    if (r0(k) && a == 0) return 16'h0000;
    if (bp(k) && m.we && m.waddr == a) return m.wdata;
    return mem[k][a];
  endfunction

  function automatic bit pred_busy(input int k, input stim_t m, input logic [3:0] a);
    if (r0(k) && a == 0) return 1'b0;
    if (bp(k) && m.we && m.waddr == a && !(m.alloc && m.aaddr == a)) return 1'b0;
    return bsy[k][a];
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      stim_t m = fit(s, k);
      bit any = 1'b0;
      for (int i = 0; i < 16; i++) any |= bsy[k][i];
      e.rd1[k]  = pred_rd(k, m, m.ra1);
      e.rd2[k]  = pred_rd(k, m, m.ra2);
      e.dbg[k]  = mem[k][m.dsel];
      e.b1[k]   = pred_busy(k, m, m.ra1);
      e.b2[k]   = pred_busy(k, m, m.ra2);
      e.bany[k] = any;
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    if0.we = s.we; if0.waddr = s.waddr[2:0]; if0.wdata = s.wdata[7:0];
    if0.raddr1 = s.ra1[2:0]; if0.raddr2 = s.ra2[2:0];
    if0.alloc = s.alloc; if0.alloc_addr = s.aaddr[2:0]; if0.dbg_sel = s.dsel[2:0];
    if1.we = s.we; if1.waddr = s.waddr[2:0]; if1.wdata = s.wdata[7:0];
    if1.raddr1 = s.ra1[2:0]; if1.raddr2 = s.ra2[2:0];
    if1.alloc = s.alloc; if1.alloc_addr = s.aaddr[2:0]; if1.dbg_sel = s.dsel[2:0];
    if2.we = s.we; if2.waddr = s.waddr; if2.wdata = s.wdata;
    if2.raddr1 = s.ra1; if2.raddr2 = s.ra2;
    if2.alloc = s.alloc; if2.alloc_addr = s.aaddr; if2.dbg_sel = s.dsel;
    if3.we = s.we; if3.waddr = s.waddr[2:0]; if3.wdata = s.wdata[7:0];
    if3.raddr1 = s.ra1[2:0]; if3.raddr2 = s.ra2[2:0];
    if3.alloc = s.alloc; if3.alloc_addr = s.aaddr[2:0]; if3.dbg_sel = s.dsel[2:0];
  endtask

  stim_t prev;
  bit    have_prev = 1'b0;
  bit    prev_rst  = 1'b1;

  // One cycle: commit the previous cycle's edge into the model, drive new inputs, push the prediction.
  task automatic cycle(input stim_t s_in, input bit rst_lo);
    stim_t s = s_in;
    @(posedge clk);
    if (have_prev && !prev_rst) model_commit(prev);
    #1;
    if (rst_lo) begin
      s.we = 1'b0;
      s.alloc = 1'b0;
    end
    apply(s);
    rst_n = !rst_lo;
    if (rst_lo) model_reset();
    exp_q.push_back(predict(s));
    prev = s;
    prev_rst = rst_lo;
    have_prev = 1'b1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.we = 1'b0; s.waddr = 4'h0; s.wdata = 16'h0000;
    s.ra1 = 4'h0; s.ra2 = 4'h0;
    s.alloc = 1'b0; s.aaddr = 4'h0; s.dsel = 4'h0;
    return s;
  endfunction

  task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: every falling edge with a pending prediction, compare all four configurations.
  initial begin
    exp_t e;
    logic [3:0][15:0] a_rd1, a_rd2, a_dbg;
    logic [3:0] a_b1, a_b2, a_ba;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a_rd1[0] = 16'(if0.rdata1); a_rd2[0] = 16'(if0.rdata2); a_dbg[0] = 16'(if0.dbg_data);
        a_rd1[1] = 16'(if1.rdata1); a_rd2[1] = 16'(if1.rdata2); a_dbg[1] = 16'(if1.dbg_data);
        a_rd1[2] = if2.rdata1;      a_rd2[2] = if2.rdata2;      a_dbg[2] = if2.dbg_data;
        a_rd1[3] = 16'(if3.rdata1); a_rd2[3] = 16'(if3.rdata2); a_dbg[3] = 16'(if3.dbg_data);
        a_b1 = {if3.busy1, if2.busy1, if1.busy1, if0.busy1};
        a_b2 = {if3.busy2, if2.busy2, if1.busy2, if0.busy2};
        a_ba = {if3.busy_any, if2.busy_any, if1.busy_any, if0.busy_any};
        for (int k = 0; k < 4; k++) begin
          check("rdata1",   k, a_rd1[k], e.rd1[k]);
          check("rdata2",   k, a_rd2[k], e.rd2[k]);
          check("dbg_data", k, a_dbg[k], e.dbg[k]);
          check("busy1",    k, 16'(a_b1[k]), 16'(e.b1[k]));
          check("busy2",    k, 16'(a_b2[k]), 16'(e.b2[k]));
          check("busy_any", k, 16'(a_ba[k]), 16'(e.bany[k]));
        end
      end
    end
  end

  // Stimulus: directed scenarios for the called-out corners, then randomized traffic.
  initial begin
    stim_t s;
    apply(idle());
    rst_n = 1'b0;
    model_reset();
    cycle(idle(), 1'b1);
    cycle(idle(), 1'b1);

    for (int d = 0; d < 16; d++) begin
      s = idle(); s.dsel = 4'(d); s.ra1 = 4'(d); s.ra2 = 4'(15 - d);
      cycle(s, 1'b0);
    end

    s = idle(); s.we = 1; s.waddr = 4'd5; s.wdata = 16'h00A5; s.ra2 = 4'd5; s.dsel = 4'd5;
    cycle(s, 1'b0);
    s = idle(); s.ra1 = 4'd5; s.dsel = 4'd5;
    cycle(s, 1'b0);

    s = idle(); s.we = 1; s.waddr = 4'd15; s.wdata = 16'hBEEF; s.ra2 = 4'd15; s.dsel = 4'd15;
    cycle(s, 1'b0);
    s = idle(); s.ra1 = 4'd15; s.dsel = 4'd15;
    cycle(s, 1'b0);

    s = idle(); s.alloc = 1; s.aaddr = 4'd3;
    cycle(s, 1'b0);
    s = idle(); s.ra1 = 4'd3;
    cycle(s, 1'b0);
    s = idle(); s.we = 1; s.waddr = 4'd3; s.wdata = 16'h007E; s.ra1 = 4'd3; s.ra2 = 4'd3;
    cycle(s, 1'b0);
    s = idle(); s.ra1 = 4'd3;
    cycle(s, 1'b0);

    s = idle(); s.alloc = 1; s.aaddr = 4'd3;
    cycle(s, 1'b0);
    s = idle(); s.alloc = 1; s.aaddr = 4'd3; s.we = 1; s.waddr = 4'd3; s.wdata = 16'h0011; s.ra1 = 4'd3;
    cycle(s, 1'b0);
    s = idle(); s.ra1 = 4'd3; s.dsel = 4'd3;
    cycle(s, 1'b0);

    s = idle(); s.we = 1; s.waddr = 4'd0; s.wdata = 16'h00FF; s.alloc = 1; s.aaddr = 4'd0; s.ra1 = 4'd0;
    cycle(s, 1'b0);
    s = idle(); s.ra1 = 4'd0; s.ra2 = 4'd3;
    cycle(s, 1'b0);

    s = idle(); s.alloc = 1; s.aaddr = 4'd2;
    cycle(s, 1'b0);
    s = idle(); s.alloc = 1; s.aaddr = 4'd4;
    cycle(s, 1'b0);
    s = idle(); s.we = 1; s.waddr = 4'd6; s.wdata = 16'h00C3; s.ra1 = 4'd2; s.ra2 = 4'd4;
    cycle(s, 1'b0);
    s = idle(); s.dsel = 4'd6; s.ra1 = 4'd6; s.ra2 = 4'd2;
    cycle(s, 1'b1);
    cycle(s, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      s.we    = ($urandom_range(0, 1) == 1);
      s.waddr = 4'($urandom_range(0, 15));
      s.wdata = 16'($urandom);
      s.ra1   = 4'($urandom_range(0, 15));
      s.ra2   = ($urandom_range(0, 3) == 0) ? s.ra1 : 4'($urandom_range(0, 15));
      s.alloc = ($urandom_range(0, 2) == 0);
      s.aaddr = ($urandom_range(0, 3) == 0) ? s.waddr : 4'($urandom_range(0, 15));
      s.dsel  = 4'($urandom_range(0, 15));
      cycle(s, $urandom_range(0, 99) == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
